regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x64 register file between two writeback requesters: port 0 (ALU writeback) and port 1 (load writeback).
- Each requester has a one-entry hold buffer with a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write port that drives RegWrite/RD/WriteData.
- Exports a pending-write mask so hazard logic can stall readers of registers with in-flight writes.

Parameters:
- DATA_WIDTH, 64, width of write data.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb0_valid  input  1  ALU writeback request.
- wb0_ready  output  1  ALU buffer can accept this cycle.
- wb0_rd  input  ADDR_WIDTH  ALU destination register.
- wb0_data  input  DATA_WIDTH  ALU result.
- wb1_valid  input  1  load writeback request.
- wb1_ready  output  1  load buffer can accept this cycle.
- wb1_rd  input  ADDR_WIDTH  load destination register.
- wb1_data  input  DATA_WIDTH  load data.
- RegWrite  output  1  register-file write enable (registered).
- RD  output  ADDR_WIDTH  register-file write index (registered).
- WriteData  output  DATA_WIDTH  register-file write data (registered).
- pending_mask  output  2**ADDR_WIDTH  bit r = 1 while a write to r is buffered or on the write port.
- conflict_count  output  CNT_WIDTH  cycles in which both buffers were valid, saturating.

Behaviour:
- Reset (reset=0, asynchronous) clears all state:
  - buf0_valid = buf1_valid = 0.
  - RegWrite = 0, RD = 0, WriteData = 0.
  - RR pointer = 0, meaning port 0 is favoured next.
  - conflict_count = 0.
  - Outputs follow at once: wb0_ready = wb1_ready = 1, pending_mask = 0.
- Asserting reset mid-operation discards buffered writes; no partial write is issued.
- Grant, combinational from buffer state:
  - Only bufX valid: grant X.
  - Both valid: grant the port the RR pointer favours.
  - After any grant of port X, the pointer favours the other port.
- Ready: wbX_ready = ~bufX_valid | grantX. A buffer being drained may be refilled on the same edge.
- Accept: on an edge with wbX_valid & wbX_ready, bufX loads {rd, data} and bufX_valid = 1. Otherwise bufX_valid clears on grant.
- Write port: on every edge, RD/WriteData load the granted buffer's rd/data, and RegWrite = (grant exists) & (rd != 0).
  - Writes to x0 are consumed and granted but never enabled.
  - With no grant, RegWrite = 0 and RD/WriteData hold.
- Latency, uncontested: request accepted at edge N; RegWrite high in the cycle after edge N+1; register file updated at edge N+2. Sustained throughput is 1 write/cycle.
- Contested: each port gets at most every other cycle while both are active, and no port waits more than 1 grant.
- Same rd from both ports in one cycle: the writes land in grant order, so the later-granted value wins in the register file.
- pending_mask (combinational), bit r set if any of:
  - buf0_valid & buf0_rd == r;
  - buf1_valid & buf1_rd == r;
  - RegWrite & RD == r.
  - Bit 0 is always 0.
- conflict_count increments on edges where buf0_valid & buf1_valid, and saturates at 2**CNT_WIDTH-1.
- Inputs are sampled only when valid & ready. While ready = 0, requesters hold valid, rd and data stable.

Test Plan:
- Reset check: reset low mid-stream with buf0 holding rd=5 -> RegWrite=0, pending_mask=0, both ready=1 immediately. After release, no write to x5 occurs.
- Single ALU write: wb0 {rd=13, data=0x2A} accepted at edge 1 -> RegWrite=1, RD=13, WriteData=0x2A after edge 2. pending_mask[13] set from edge 1 until RegWrite drops.
- Back-to-back: wb0 valid for 4 cycles with rd=1..4 and wb1 idle -> 4 consecutive RegWrite cycles, RD=1,2,3,4, and wb0_ready stays 1.
- Contention: both ports valid every cycle, wb0 rd=6 data=0x11, wb1 rd=7 data=0x22 -> RD alternates 6,7,6,7 starting with 6. conflict_count increments each cycle; neither port waits more than 1 grant.
- Same-rd collision: both ports request rd=9 on the same edge (0xAA on port 0, 0xBB on port 1) with pointer favouring port 1 -> writes 0xBB then 0xAA, so x9 ends at 0xAA.
- x0 write: wb1 {rd=0, data=0xFF} -> accepted and granted, RegWrite stays 0, pending_mask[0]=0. Separately, force conflict_count to saturation and hold contention -> counter stays at 0xFFFF.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the single register-file write port between the ALU
//               writeback (port 0) and the load writeback (port 1). Each port
//               has a one-entry hold buffer. A round-robin arbiter drains the
//               buffers into a registered write port. The module also exports a
//               mask of registers with in-flight writes and counts contended
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb0_valid,
    output logic                      wb0_ready,
    input  logic [ADDR_WIDTH-1:0]     wb0_rd,
    input  logic [DATA_WIDTH-1:0]     wb0_data,
    input  logic                      wb1_valid,
    output logic                      wb1_ready,
    input  logic [ADDR_WIDTH-1:0]     wb1_rd,
    input  logic [DATA_WIDTH-1:0]     wb1_data,
    output logic                      RegWrite,
    output logic [ADDR_WIDTH-1:0]     RD,
    output logic [DATA_WIDTH-1:0]     WriteData,
    output logic [2**ADDR_WIDTH-1:0]  pending_mask,
    output logic [CNT_WIDTH-1:0]      conflict_count
);

    localparam int                   NREGS   = 2**ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Hold buffers
    logic                  buf0_valid_q, buf0_valid_d;
    logic [ADDR_WIDTH-1:0] buf0_rd_q,    buf0_rd_d;
    logic [DATA_WIDTH-1:0] buf0_data_q,  buf0_data_d;
    logic                  buf1_valid_q, buf1_valid_d;
    logic [ADDR_WIDTH-1:0] buf1_rd_q,    buf1_rd_d;
    logic [DATA_WIDTH-1:0] buf1_data_q,  buf1_data_d;

    // Round-robin pointer: 0 favours port 0, 1 favours port 1
    logic                  rr_q, rr_d;

    // Registered write port
    logic                  regwrite_q, regwrite_d;
    logic [ADDR_WIDTH-1:0] rd_q,       rd_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;

    logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;

    logic                  grant0, grant1, grant_any;
    logic                  accept0, accept1;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;

    // Grant comes straight from buffer state; the pointer only breaks ties.
    assign grant0    = buf0_valid_q & (~buf1_valid_q | ~rr_q);
    assign grant1    = buf1_valid_q & (~buf0_valid_q |  rr_q);
    assign grant_any = grant0 | grant1;

    // A buffer being drained this cycle can take a new entry on the same edge.
    assign wb0_ready = ~buf0_valid_q | grant0;
    assign wb1_ready = ~buf1_valid_q | grant1;
    assign accept0   = wb0_valid & wb0_ready;
    assign accept1   = wb1_valid & wb1_ready;

    assign grant_rd   = grant1 ? buf1_rd_q   : buf0_rd_q;
    assign grant_data = grant1 ? buf1_data_q : buf0_data_q;

    assign RegWrite       = regwrite_q;
    assign RD             = rd_q;
    assign WriteData      = wdata_q;
    assign conflict_count = cnt_q;

    // Next-state for buffers, pointer, write port and conflict counter
    always_comb begin
        buf0_valid_d = buf0_valid_q;
        buf0_rd_d    = buf0_rd_q;
        buf0_data_d  = buf0_data_q;
        buf1_valid_d = buf1_valid_q;
        buf1_rd_d    = buf1_rd_q;
        buf1_data_d  = buf1_data_q;
        rr_d         = rr_q;
        regwrite_d   = 1'b0;
        rd_d         = rd_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;

        if (accept0) begin
            buf0_valid_d = 1'b1;
            buf0_rd_d    = wb0_rd;
            buf0_data_d  = wb0_data;
        end else if (grant0) begin
            buf0_valid_d = 1'b0;
        end

        if (accept1) begin
            buf1_valid_d = 1'b1;
            buf1_rd_d    = wb1_rd;
            buf1_data_d  = wb1_data;
        end else if (grant1) begin
            buf1_valid_d = 1'b0;
        end

        // After serving a port, favour the other one
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end

        // x0 writes are consumed but never enabled on the register file
        if (grant_any) begin
            regwrite_d = (grant_rd != '0);
            rd_d       = grant_rd;
            wdata_d    = grant_data;
        end

        if (buf0_valid_q && buf1_valid_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf0_valid_q <= 1'b0;
            buf0_rd_q    <= '0;
            buf0_data_q  <= '0;
            buf1_valid_q <= 1'b0;
            buf1_rd_q    <= '0;
            buf1_data_q  <= '0;
            rr_q         <= 1'b0;
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            buf0_valid_q <= buf0_valid_d;
            buf0_rd_q    <= buf0_rd_d;
            buf0_data_q  <= buf0_data_d;
            buf1_valid_q <= buf1_valid_d;
            buf1_rd_q    <= buf1_rd_d;
            buf1_data_q  <= buf1_data_d;
            rr_q         <= rr_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Pending mask: buffered entries plus the write currently on the port; x0 never pending
    always_comb begin
        pending_mask = '0;
        for (int r = 1; r < NREGS; r++) begin
            if ((buf0_valid_q && (buf0_rd_q == ADDR_WIDTH'(r))) ||
                (buf1_valid_q && (buf1_rd_q == ADDR_WIDTH'(r))) ||
                (regwrite_q   && (rd_q      == ADDR_WIDTH'(r)))) begin
                pending_mask[r] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter. Expected writes
//               are queued when stimulus is driven and compared as the write
//               port produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 16;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [AW-1:0] wb0_rd, wb1_rd;
    logic [DW-1:0] wb0_data, wb1_data;
    logic          RegWrite;
    logic [AW-1:0] RD;
    logic [DW-1:0] WriteData;
    logic [31:0]   pending_mask;
    logic [CW-1:0] conflict_count;

    int            n_checks = 0;
    int            n_fails  = 0;
    wr_t           sb[$];
    logic [DW-1:0] rf[32];

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .pending_mask(pending_mask), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        wb0_rd = '0; wb1_rd = '0; wb0_data = '0; wb1_data = '0;
        tick(); tick();
        n_checks++;
        if (RegWrite !== 1'b0 || RD !== '0 || WriteData !== '0) begin
            n_fails++;
            $display("FAIL reset_port: got we=%b rd=%0d data=%h, required 0/0/0", RegWrite, RD, WriteData);
        end
        n_checks++;
        if (pending_mask !== 32'h0 || conflict_count !== '0) begin
            n_fails++;
            $display("FAIL reset_mask_cnt: got mask=%h cnt=%0d, required 0/0", pending_mask, conflict_count);
        end
        n_checks++;
        if (wb0_ready !== 1'b1 || wb1_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_ready: got %b%b, required 11", wb0_ready, wb1_ready);
        end
        reset = 1'b1;
        // Load x5 into buf0 then reset before it can be granted
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 64'h55;
        tick();
        wb0_valid = 1'b0;
        n_checks++;
        if (pending_mask !== 32'h20) begin
            n_fails++;
            $display("FAIL reset_pre_mask: got %h, required %h", pending_mask, 32'h20);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (RegWrite !== 1'b0 || pending_mask !== 32'h0 || wb0_ready !== 1'b1 || wb1_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_async: got we=%b mask=%h rdy=%b%b, required 0/0/11", RegWrite, pending_mask, wb0_ready, wb1_ready);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (RegWrite !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_discard: got we=%b rd=%0d, required no write", RegWrite, RD);
            end
        end
    endtask

    task automatic test_single_alu();
        wr_t e;
        logic [31:0] exp_pm;
        wb0_valid = 1'b1; wb0_rd = 5'd13; wb0_data = 64'h2A;
        sb.push_back('{rd: 5'd13, data: 64'h2A});
        n_checks++;
        if (wb0_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL single_ready: got %b, required 1", wb0_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            wb0_valid = 1'b0;
            exp_pm = (k <= 2) ? (32'h1 << 13) : 32'h0;
            n_checks++;
            if (RegWrite !== (k == 2) || pending_mask !== exp_pm) begin
                n_fails++;
                $display("FAIL single_timing edge%0d: got we=%b mask=%h, required we=%b mask=%h", k, RegWrite, pending_mask, (k == 2), exp_pm);
            end
            if (RegWrite === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL single_sb: got write rd=%0d, required none", RD);
                end else begin
                    e = sb.pop_front();
                    rf[RD] = WriteData;
                    if (RD !== e.rd || WriteData !== e.data) begin
                        n_fails++;
                        $display("FAIL single_sb: got rd=%0d data=%h, required rd=%0d data=%h", RD, WriteData, e.rd, e.data);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL single_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) begin
                wb0_valid = 1'b1; wb0_rd = AW'(k); wb0_data = 64'h100 + 64'(k);
                sb.push_back('{rd: AW'(k), data: 64'h100 + 64'(k)});
                n_checks++;
                if (wb0_ready !== 1'b1) begin
                    n_fails++;
                    $display("FAIL b2b_ready k=%0d: got %b, required 1", k, wb0_ready);
                end
            end else begin
                wb0_valid = 1'b0;
            end
            tick();
            n_checks++;
            if (RegWrite !== (k >= 2 && k <= 5)) begin
                n_fails++;
                $display("FAIL b2b_we edge%0d: got %b, required %b", k, RegWrite, (k >= 2 && k <= 5));
            end
            if (RegWrite === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL b2b_sb: got write rd=%0d, required none", RD);
                end else begin
                    e = sb.pop_front();
                    rf[RD] = WriteData;
                    if (RD !== e.rd || WriteData !== e.data) begin
                        n_fails++;
                        $display("FAIL b2b_sb: got rd=%0d data=%h, required rd=%0d data=%h", RD, WriteData, e.rd, e.data);
                    end
                end
            end
        end
        wb0_valid = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL b2b_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_contention();
        wr_t e;
        logic [CW-1:0] exp_cnt;
        pulse_reset();
        wb0_rd = 5'd6; wb0_data = 64'h11;
        wb1_rd = 5'd7; wb1_data = 64'h22;
        // Nine accepts in total; grants alternate starting with port 0
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) sb.push_back('{rd: 5'd6, data: 64'h11});
            else            sb.push_back('{rd: 5'd7, data: 64'h22});
        end
        for (int k = 1; k <= 10; k++) begin
            wb0_valid = (k <= 9);
            wb1_valid = (k <= 8);
            if (k >= 2 && k <= 9) begin
                n_checks++;
                if (wb0_ready !== (k % 2 == 0) || wb1_ready !== (k % 2 == 1)) begin
                    n_fails++;
                    $display("FAIL cont_ready edge%0d: got %b%b, required %b%b", k, wb0_ready, wb1_ready, (k % 2 == 0), (k % 2 == 1));
                end
            end
            tick();
            exp_cnt = (k == 1) ? CW'(0) : ((k <= 9) ? CW'(k - 1) : CW'(8));
            n_checks++;
            if (conflict_count !== exp_cnt || RegWrite !== (k >= 2)) begin
                n_fails++;
                $display("FAIL cont_cnt edge%0d: got cnt=%0d we=%b, required cnt=%0d we=%b", k, conflict_count, RegWrite, exp_cnt, (k >= 2));
            end
            if (RegWrite === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL cont_sb: got write rd=%0d, required none", RD);
                end else begin
                    e = sb.pop_front();
                    rf[RD] = WriteData;
                    if (RD !== e.rd || WriteData !== e.data) begin
                        n_fails++;
                        $display("FAIL cont_sb: got rd=%0d data=%h, required rd=%0d data=%h", RD, WriteData, e.rd, e.data);
                    end
                end
            end
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        n_checks++;
        if (sb.size() != 0 || pending_mask !== (32'h1 << 6)) begin
            n_fails++;
            $display("FAIL cont_drain: got %0d outstanding mask=%h, required 0 mask=%h", sb.size(), pending_mask, 32'h1 << 6);
        end
    endtask

    task automatic test_same_rd();
        wr_t e;
        pulse_reset();
        // A single port-0 grant leaves the pointer favouring port 1
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 64'h33;
        sb.push_back('{rd: 5'd3, data: 64'h33});
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) begin
                wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 64'hAA;
                wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 64'hBB;
                sb.push_back('{rd: 5'd9, data: 64'hBB});
                sb.push_back('{rd: 5'd9, data: 64'hAA});
            end else if (k != 1) begin
                wb0_valid = 1'b0; wb1_valid = 1'b0;
            end
            tick();
            if (k == 1) wb0_valid = 1'b0;
            if (k == 3) begin
                n_checks++;
                if (pending_mask !== (32'h1 << 9)) begin
                    n_fails++;
                    $display("FAIL same_mask: got %h, required %h", pending_mask, 32'h1 << 9);
                end
            end
            if (RegWrite === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL same_sb: got write rd=%0d, required none", RD);
                end else begin
                    e = sb.pop_front();
                    rf[RD] = WriteData;
                    if (RD !== e.rd || WriteData !== e.data) begin
                        n_fails++;
                        $display("FAIL same_sb: got rd=%0d data=%h, required rd=%0d data=%h", RD, WriteData, e.rd, e.data);
                    end
                end
            end
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        n_checks++;
        if (rf[9] !== 64'hAA || sb.size() != 0) begin
            n_fails++;
            $display("FAIL same_final: got x9=%h outstanding=%0d, required x9=%h outstanding=0", rf[9], sb.size(), 64'hAA);
        end
    endtask

    task automatic test_x0_write();
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 64'hFF;
        tick();
        wb1_valid = 1'b0;
        n_checks++;
        if (pending_mask !== 32'h0 || wb1_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL x0_buffered: got mask=%h rdy=%b, required mask=0 rdy=1", pending_mask, wb1_ready);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b0 || RD !== 5'd0 || WriteData !== 64'hFF) begin
            n_fails++;
            $display("FAIL x0_port: got we=%b rd=%0d data=%h, required we=0 rd=0 data=ff", RegWrite, RD, WriteData);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b0 || pending_mask !== 32'h0) begin
            n_fails++;
            $display("FAIL x0_after: got we=%b mask=%h, required 0/0", RegWrite, pending_mask);
        end
    endtask

    task automatic test_saturation();
        wr_t e;
        pulse_reset();
        wb0_valid = 1'b1; wb0_rd = 5'd6; wb0_data = 64'h11;
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 64'h22;
        for (int k = 1; k <= 65540; k++) begin
            // Each grant frees a buffer that is refilled on the same edge
            if (k >= 2) begin
                if (k % 2 == 0) sb.push_back('{rd: 5'd6, data: 64'h11});
                else            sb.push_back('{rd: 5'd7, data: 64'h22});
            end
            tick();
            if (RegWrite === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                if (k >= 65530) begin
                    n_checks++;
                    if (RD !== e.rd || WriteData !== e.data) begin
                        n_fails++;
                        $display("FAIL sat_sb edge%0d: got rd=%0d data=%h, required rd=%0d data=%h", k, RD, WriteData, e.rd, e.data);
                    end
                end
            end
            if (k == 65535) begin
                n_checks++;
                if (conflict_count !== 16'hFFFE) begin
                    n_fails++;
                    $display("FAIL sat_pre: got %h, required fffe", conflict_count);
                end
            end
            if (k >= 65536) begin
                n_checks++;
                if (conflict_count !== 16'hFFFF) begin
                    n_fails++;
                    $display("FAIL sat_hold edge%0d: got %h, required ffff", k, conflict_count);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL sat_drain: got %0d outstanding, required 0", sb.size());
        end
        pulse_reset();
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_single_alu();
        test_back_to_back();
        test_contention();
        test_same_rd();
        test_x0_write();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
